// File: rtl/rtype_pkg.sv
// rtype_pkg: shared definitions for the R-type multi-cycle controller.
// Holds the FSM state encoding, the opcode/funct values the controller
// accepts, the ALU operation codes driven onto ALU_OP, and the bit positions
// of the instruction fields within the instruction register.
package rtype_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SRLV = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 26;
  localparam int IR_RS_HI = 25;
  localparam int IR_RS_LO = 21;
  localparam int IR_RT_HI = 20;
  localparam int IR_RT_LO = 16;
  localparam int IR_RD_HI = 15;
  localparam int IR_RD_LO = 11;
  localparam int IR_SH_HI = 10;
  localparam int IR_SH_LO = 6;
  localparam int IR_FN_HI = 5;
  localparam int IR_FN_LO = 0;

endpackage

// File: rtl/rtype_decode.sv
// rtype_decode: combinational opcode/funct decoder.
// Ports:
//   opcode    in  6  IR[31:26]
//   funct     in  6  IR[5:0]
//   alu_op    out 3  ALU operation (000 when illegal)
//   legal     out 1  instruction is a supported R-type op
//   signed_op out 1  ADD or SUB (the ops whose overflow is meaningful)
module rtype_decode
  import rtype_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal,
  output logic       signed_op
);

  always_comb begin
    alu_op    = OP_AND;
    legal     = 1'b1;
    signed_op = 1'b0;
    case (funct)
      FN_AND:  alu_op = OP_AND;
      FN_OR:   alu_op = OP_OR;
      FN_ADD:  begin alu_op = OP_ADD; signed_op = 1'b1; end
      FN_ADDU: alu_op = OP_ADD;
      FN_XOR:  alu_op = OP_XOR;
      FN_NOR:  alu_op = OP_NOR;
      FN_SRLV: alu_op = OP_SRLV;
      FN_SUB:  begin alu_op = OP_SUB; signed_op = 1'b1; end
      FN_SUBU: alu_op = OP_SUB;
      FN_SLT:  alu_op = OP_SLT;
      default: legal = 1'b0;
    endcase
    if (opcode != OPC_RTYPE) begin
      legal = 1'b0;
    end
    if (!legal) begin
      alu_op    = OP_AND;
      signed_op = 1'b0;
    end
  end

endmodule

// File: rtl/rtype_ctrl.sv
// rtype_ctrl: multi-cycle control FSM for the R-type datapath.
// Holds the instruction register, decodes it and sequences
// fetch -> decode (operand read) -> execute -> write-back, advancing only on
// cycles where EN=1. Every strobe is a Moore decode of state ANDed with EN.
// Parameter: FETCH_WAIT (1..15) instruction-memory latency in EN cycles.
// Ports:
//   CLK, RST (async, active-high), EN advance enable
//   INST[31:0] imem data, ALU_ZF/ALU_OF ALU flags
//   AB_WE, RES_WE, RF_WE, PC_WE strobes; ALU_OP[2:0]; RS/RT/RD fields
//   ZF_Q/OF_Q flags captured in EXEC; TRAP; STATE[2:0]; RETIRED[15:0]
// Build option: define RTYPE_OVF_TRAP_EN to trap on signed ADD/SUB overflow
// instead of only recording it in OF_Q.
//
// state  | meaning
// FETCH  | wait FETCH_WAIT+1 EN cycles for imem, then latch IR
// DECODE | operand read (AB_WE); illegal instruction -> TRAP
// EXEC   | ALU result latch (RES_WE), capture ZF/OF
// WB     | register write (unless RD=0), PC+4, count retirement
// TRAP   | halted, all strobes low; left only through RST
module rtype_ctrl
  import rtype_pkg::*;
#(
  parameter int FETCH_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] INST,
  input  logic        ALU_ZF,
  input  logic        ALU_OF,
  output logic        AB_WE,
  output logic        RES_WE,
  output logic        RF_WE,
  output logic        PC_WE,
  output logic [2:0]  ALU_OP,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  RD,
  output logic        ZF_Q,
  output logic        OF_Q,
  output logic        TRAP,
  output logic [2:0]  STATE,
  output logic [15:0] RETIRED
);

  localparam logic [3:0] WAIT_TC = 4'(FETCH_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] ir_q, ir_d;
  logic        zf_q, zf_d;
  logic        of_q, of_d;
  logic [15:0] retired_q, retired_d;

  logic [2:0]  dec_alu_op;
  logic        dec_legal;
  logic        dec_signed;
  logic        ovf_trap;

  rtype_decode u_decode (
    .opcode    (ir_q[IR_OP_HI:IR_OP_LO]),
    .funct     (ir_q[IR_FN_HI:IR_FN_LO]),
    .alu_op    (dec_alu_op),
    .legal     (dec_legal),
    .signed_op (dec_signed)
  );

`ifdef RTYPE_OVF_TRAP_EN
  assign ovf_trap = dec_signed & ALU_OF;
`else
  // Overflow is only recorded in OF_Q; the signed-op flag has no consumer.
  logic unused_signed;
  assign unused_signed = dec_signed;
  assign ovf_trap      = 1'b0;
`endif

  // Shift amount is not used by any supported op.
  logic unused_shamt;
  assign unused_shamt = ^ir_q[IR_SH_HI:IR_SH_LO];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ir_q      <= ir_d;
      zf_q      <= zf_d;
      of_q      <= of_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ir_d      = ir_q;
    zf_d      = zf_q;
    of_d      = of_q;
    retired_d = retired_q;
    if (EN) begin
      case (state_q)
        ST_FETCH: begin
          if (wait_q == WAIT_TC) begin
            ir_d    = INST;
            wait_d  = '0;
            state_d = ST_DECODE;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          zf_d    = ALU_ZF;
          of_d    = ALU_OF;
          state_d = ovf_trap ? ST_TRAP : ST_WB;
        end
        ST_WB: begin
          retired_d = retired_q + 16'd1;
          state_d   = ST_FETCH;
        end
        // TRAP and any unused encoding park in TRAP.
        default: state_d = ST_TRAP;
      endcase
    end
  end

  always_comb begin
    AB_WE  = 1'b0;
    RES_WE = 1'b0;
    RF_WE  = 1'b0;
    PC_WE  = 1'b0;
    ALU_OP = OP_AND;
    case (state_q)
      ST_DECODE: begin
        AB_WE  = EN;
        ALU_OP = dec_alu_op;
      end
      ST_EXEC: begin
        RES_WE = EN;
        ALU_OP = dec_alu_op;
      end
      ST_WB: begin
        RF_WE  = EN & (ir_q[IR_RD_HI:IR_RD_LO] != 5'd0);
        PC_WE  = EN;
        ALU_OP = dec_alu_op;
      end
      default: ;
    endcase
  end

  assign RS      = ir_q[IR_RS_HI:IR_RS_LO];
  assign RT      = ir_q[IR_RT_HI:IR_RT_LO];
  assign RD      = ir_q[IR_RD_HI:IR_RD_LO];
  assign ZF_Q    = zf_q;
  assign OF_Q    = of_q;
  assign TRAP    = (state_q == ST_TRAP);
  assign STATE   = state_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_rtype_ctrl.sv
// tb_rtype_ctrl: self-checking bench for rtype_ctrl (FETCH_WAIT=1).
// Each instruction expected to retire pushes its expected write-back view
// onto a queue; a negedge monitor pops one entry per observed PC_WE and
// compares RD, ALU_OP, RF_WE, captured flags and RETIRED.
module tb_rtype_ctrl;

  logic        CLK = 1'b0;
  logic        RST, EN, ALU_ZF, ALU_OF;
  logic [31:0] INST;
  logic        AB_WE, RES_WE, RF_WE, PC_WE, ZF_Q, OF_Q, TRAP;
  logic [2:0]  ALU_OP, STATE;
  logic [4:0]  RS, RT, RD;
  logic [15:0] RETIRED;

  rtype_ctrl #(.FETCH_WAIT(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .INST(INST), .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF),
    .AB_WE(AB_WE), .RES_WE(RES_WE), .RF_WE(RF_WE), .PC_WE(PC_WE), .ALU_OP(ALU_OP),
    .RS(RS), .RT(RT), .RD(RD), .ZF_Q(ZF_Q), .OF_Q(OF_Q), .TRAP(TRAP),
    .STATE(STATE), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] alu_op;
    logic       rf_we;
    logic       zf;
    logic       of;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] retired_exp = '0;

  logic [5:0] fn_tab [10] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h26, 6'h27, 6'h06, 6'h22, 6'h23, 6'h2A};
  logic [2:0] op_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-back monitor and quiet-strobe checks.
  always @(negedge CLK) begin
    if (RST || !EN || TRAP)
      chk("quiet_strobes", {AB_WE, RES_WE, RF_WE, PC_WE}, 4'b0000);
    if (RF_WE && !PC_WE)
      chk("rf_without_pc", RF_WE, 1'b0);
    if (PC_WE) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wb", PC_WE, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd", RD, e.rd);
        chk("wb_alu_op", ALU_OP, e.alu_op);
        chk("wb_rf_we", RF_WE, e.rf_we);
        chk("wb_zf_q", ZF_Q, e.zf);
        chk("wb_of_q", OF_Q, e.of);
        chk("wb_retired", RETIRED, retired_exp);
        retired_exp = retired_exp + 16'd1;
      end
    end
  end

  task automatic apply_reset();
    RST = 1'b1; EN = 1'b0; INST = '0; ALU_ZF = 1'b0; ALU_OF = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    sb_q.delete();
    retired_exp = '0;
    RST = 1'b0;
  endtask

  // Runs one instruction from FETCH until its PC_WE cycle or TRAP.
  // log holds the first five EN-qualified strobe vectors {AB,RES,RF,PC}.
  task automatic run_instr(input logic [31:0] inst, input bit toggle, input logic zf,
                           input logic of, output logic [19:0] log, output int n);
    bit finished = 0;
    bit done;
    log = '0; n = 0;
    INST = inst; ALU_ZF = zf; ALU_OF = of;
    for (int c = 0; c < 80; c++) begin
      EN = toggle ? ~c[0] : 1'b1;
      #2;
      if (TRAP) begin
        finished = 1;
        break;
      end
      if (EN) begin
        if (n < 5) log = {log[15:0], AB_WE, RES_WE, RF_WE, PC_WE};
        n++;
      end
      done = EN && PC_WE;
      @(posedge CLK); #1;
      if (done) begin
        finished = 1;
        break;
      end
    end
    chk("run_bounded", finished, 1'b1);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  logic [19:0] log;
  int          n;
  logic [4:0]  rd_r;
  logic        zf_r;
  bit          found;

  initial begin
    apply_reset();
    chk("rst_state", STATE, 3'd0);
    chk("rst_trap", TRAP, 1'b0);
    chk("rst_retired", RETIRED, 16'd0);
    chk("rst_alu_op", ALU_OP, 3'd0);
    chk("rst_strobes", {AB_WE, RES_WE, RF_WE, PC_WE}, 4'b0000);
    chk("rst_flags", {ZF_Q, OF_Q}, 2'b00);
    chk("rst_fields", {RS, RT, RD}, 15'd0);

    // add $1,$2,$3 with EN high: AB cycle 3, RES 4, RF+PC 5
    sb_q.push_back('{rd: 5'd1, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b0, of: 1'b0});
    run_instr(32'h00430820, 0, 1'b0, 1'b0, log, n);
    chk("add_seq", log, 20'h00843);
    chk("add_cycles", n, 5);
    chk("add_retired", RETIRED, 16'd1);
    chk("add_fields", {RS, RT, RD}, {5'd2, 5'd3, 5'd1});
    chk("fetch_alu_op", ALU_OP, 3'd0);

    // same instruction with EN toggling
    sb_q.push_back('{rd: 5'd1, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b0, of: 1'b0});
    run_instr(32'h00430820, 1, 1'b0, 1'b0, log, n);
    chk("toggle_seq", log, 20'h00843);
    chk("toggle_cycles", n, 5);
    chk("toggle_retired", RETIRED, 16'd2);

    // RD=1 writes, RD=0 suppresses RF_WE but still advances PC
    sb_q.push_back('{rd: 5'd1, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b1, of: 1'b0});
    run_instr(32'h00000820, 0, 1'b1, 1'b0, log, n);
    chk("rd1_seq", log, 20'h00843);
    sb_q.push_back('{rd: 5'd0, alu_op: 3'd2, rf_we: 1'b0, zf: 1'b0, of: 1'b0});
    run_instr(32'h00430020, 0, 1'b0, 1'b0, log, n);
    chk("rd0_seq", log, 20'h00841);

    // every legal funct
    for (int i = 0; i < 10; i++) begin
      rd_r = 5'($urandom_range(0, 31));
      zf_r = 1'($urandom_range(0, 1));
      sb_q.push_back('{rd: rd_r, alu_op: op_tab[i], rf_we: (rd_r != 5'd0), zf: zf_r, of: 1'b0});
      run_instr(rtype(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rd_r, fn_tab[i]),
                i[0], zf_r, 1'b0, log, n);
      chk("funct_cycles", n, 5);
    end

    // unsigned ops never trap on overflow
    sb_q.push_back('{rd: 5'd4, alu_op: 3'd6, rf_we: 1'b1, zf: 1'b0, of: 1'b1});
    run_instr(rtype(5'd2, 5'd3, 5'd4, 6'h23), 0, 1'b0, 1'b1, log, n);
    chk("subu_ovf_trap", TRAP, 1'b0);
    sb_q.push_back('{rd: 5'd5, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b0, of: 1'b1});
    run_instr(rtype(5'd2, 5'd3, 5'd5, 6'h21), 0, 1'b0, 1'b1, log, n);
    chk("addu_ovf_trap", TRAP, 1'b0);

    // RETIRED wrap 0xFFFE -> 0xFFFF -> 0x0000
    EN = 1'b0;
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    retired_exp = 16'hFFFE;
    repeat (2) begin
      sb_q.push_back('{rd: 5'd1, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b0, of: 1'b0});
      run_instr(32'h00430820, 0, 1'b0, 1'b0, log, n);
    end
    chk("retired_wrap", RETIRED, 16'h0000);

    // signed SUB overflow
`ifdef RTYPE_OVF_TRAP_EN
    run_instr(32'h00430822, 0, 1'b0, 1'b1, log, n);
    chk("sub_ovf_seq", log, 20'h00084);
    chk("sub_ovf_trap", TRAP, 1'b1);
    chk("sub_ovf_retired", RETIRED, 16'h0000);
`else
    sb_q.push_back('{rd: 5'd1, alu_op: 3'd6, rf_we: 1'b1, zf: 1'b0, of: 1'b1});
    run_instr(32'h00430822, 0, 1'b0, 1'b1, log, n);
    chk("sub_ovf_trap", TRAP, 1'b0);
    chk("sub_ovf_retired", RETIRED, 16'h0001);
    chk("sub_ovf_of_q", OF_Q, 1'b1);
`endif
    apply_reset();

    // illegal opcode, then illegal funct: trap after DECODE, stays there
    for (int k = 0; k < 2; k++) begin
      run_instr((k == 0) ? 32'h20010001 : 32'h0043083F, 0, 1'b0, 1'b0, log, n);
      chk("illegal_seq", log, 20'h00008);
      chk("illegal_cycles", n, 3);
      chk("illegal_trap", TRAP, 1'b1);
      chk("illegal_state", STATE, 3'd7);
      EN = 1'b1;
      repeat (10) begin @(posedge CLK); #1; end
      chk("trap_sticky", TRAP, 1'b1);
      chk("trap_alu_op", ALU_OP, 3'd0);
      apply_reset();
      chk("trap_reset_state", STATE, 3'd0);
      chk("trap_reset_trap", TRAP, 1'b0);
    end

    // asynchronous reset during EXEC aborts the instruction
    INST = 32'h00430820; ALU_ZF = 1'b0; ALU_OF = 1'b0; EN = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #2;
      if (STATE == 3'd2) found = 1;
      else begin @(posedge CLK); #1; end
    end
    chk("exec_reached", found, 1'b1);
    RST = 1'b1;
    #1;
    chk("async_rst_state", STATE, 3'd0);
    chk("async_rst_strobes", {AB_WE, RES_WE, RF_WE, PC_WE}, 4'b0000);
    @(posedge CLK); #1;
    sb_q.delete();
    retired_exp = '0;
    RST = 1'b0;
    chk("async_rst_retired", RETIRED, 16'd0);
    sb_q.push_back('{rd: 5'd1, alu_op: 3'd2, rf_we: 1'b1, zf: 1'b0, of: 1'b0});
    run_instr(32'h00430820, 0, 1'b0, 1'b0, log, n);
    chk("restart_seq", log, 20'h00843);
    chk("restart_retired", RETIRED, 16'd1);

    EN = 1'b0;
    repeat (2) @(posedge CLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
